addint_arbiter: RTL and testbench
=================================

Name: addint_arbiter

Overview:
- Shares one combinational signed add/subtract datapath among NREQ requesters. Each requester is a DFT butterfly or accumulator stage.
- Round-robin arbitration selects one requester per cycle and feeds its operands through the adder. The result is captured in a one-entry output register, tagged with the requester ID.
- Valid/ready handshake on both sides. Removes per-stage adder duplication in the DFT datapath.

Parameters:
WIDTH, 32, operand/result width in bits (signed two's complement)
NREQ, 4, number of requesters (>= 2)
IDW, $clog2(NREQ), requester ID width (derived; not overridden)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  NREQ  bit i: requester i has an operation pending
req_ready  output  NREQ  bit i: requester i accepted this cycle (one-hot or zero)
req_sub  input  NREQ  bit i: 0 = x+y, 1 = x-y for requester i
req_x  input  NREQ*WIDTH  operand x, requester i at bits [i*WIDTH +: WIDTH]
req_y  input  NREQ*WIDTH  operand y, same packing
out_valid  output  1  output register holds a result
out_ready  input  1  consumer takes result this cycle
out_id  output  IDW  requester index that produced the result
out_result  output  WIDTH  x+y or x-y, modulo 2^WIDTH
out_cout  output  1  unsigned carry out (subtract: 1 = borrow, x<y unsigned)
out_ovfl  output  1  signed overflow of the operation

Behaviour:
- Clock/reset: one clock domain (clk). Reset is synchronous and active-high (rst).
- Reset (rst=1 at an edge):
  - out_valid=0; out_id, out_result, out_cout, out_ovfl = 0.
  - Round-robin pointer ptr=0.
  - req_ready=0 while rst is high.
  - Reset mid-operation discards any held result; no partial transfer survives.
- Slot state: two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- Slot available (avail) = EMPTY or (FULL and out_ready).
- Arbitration (combinational):
  - Scan requesters in order ptr, ptr+1, ..., ptr+NREQ-1, all mod NREQ.
  - The first i with req_valid[i]=1 is granted.
  - req_ready[i] = avail and granted[i].
  - req_ready is never asserted for a requester with req_valid=0.
- Transfer: requester i transfers when req_valid[i] and req_ready[i] are both high at an edge. On that edge:
  - out_result, out_cout, out_ovfl load the adder outputs for requester i's (x, y, sub).
  - out_id=i and out_valid=1.
  - ptr = (i+1) mod NREQ.
- Adder semantics: result = x + (y XOR {WIDTH{sub}}) + sub.
  - cout = carry_out XOR sub.
  - ovfl = carry into MSB XOR carry out of MSB.
- Drain: out_valid and out_ready at an edge with no new transfer -> out_valid=0. Data registers hold their last value.
- Simultaneous drain and accept: the new result replaces the old in the same edge; out_valid stays 1. Throughput is 1 op/cycle sustained.
- Backpressure: FULL and out_ready=0 -> all req_ready=0. Output registers and ptr hold.
- Requester obligations: keep req_valid, req_sub, req_x, req_y stable until accepted. The arbiter does not latch non-granted inputs.
- ptr changes only on a transfer. With no req_valid, ptr holds.
- Latency: one cycle from accepting edge to out_valid=1.
- out_ready has no combinational path to out_* signals. It does reach req_ready through avail.
- out_* signals are stable while out_valid=1 and out_ready=0.

Test Plan:
1. Reset, then requester 2 alone: sub=0, x=5, y=-3, out_ready=1 -> next cycle out_valid=1, out_id=2, out_result=2, out_cout=1, out_ovfl=0. Then ptr=3.
2. Subtraction overflow: req0 sub=1, x=0x80000000, y=1 -> out_result=0x7FFFFFFF, out_ovfl=1, out_cout=0. Also x=3, y=5, sub=1 -> out_result=-2, out_cout=1 (borrow).
3. All four requesters valid continuously, out_ready=1 -> grant order 0,1,2,3,0,... One result every cycle, out_id matching, no requester starved.
4. Backpressure: hold out_ready=0 after one result while req1 and req3 are valid.
   - req_ready stays 0; out_* stay frozen for 5 cycles.
   - Raise out_ready -> the next grant goes to the requester after the last out_id, and is accepted in the same cycle the old result drains.
5. Reset mid-stream: assert rst for one cycle while FULL with out_ready=0 -> out_valid=0 and ptr=0. Afterwards req0 wins over req3 when both are valid.
6. Parameter sweep NREQ=3, WIDTH=8: req1 and req2 valid with ptr=2 -> req2 granted first, then req1. x=127, y=1, sub=0 -> out_result=0x80, out_ovfl=1.

Source files
------------

// File: rtl/addint_arbiter_if.sv
// Requester and result handshake bundle for the shared adder arbiter.
// master drives operations and consumes results; slave is the arbiter.
interface addint_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_sub;
  logic [NREQ*WIDTH-1:0] req_x;
  logic [NREQ*WIDTH-1:0] req_y;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDW-1:0]        out_id;
  logic [WIDTH-1:0]      out_result;
  logic                  out_cout;
  logic                  out_ovfl;

  modport master (
    output req_valid, req_sub, req_x, req_y, out_ready,
    input  req_ready, out_valid, out_id, out_result,
    input  out_cout, out_ovfl
  );

  modport slave (
    input  req_valid, req_sub, req_x, req_y, out_ready,
    output req_ready, out_valid, out_id, out_result,
    output out_cout, out_ovfl
  );
endinterface

// File: rtl/addint_arbiter.sv
// Round-robin shared signed add/subtract unit with a
// one-entry tagged result register.
module addint_arbiter #(
  parameter int WIDTH = 32,
  parameter int NREQ  = 4
) (
  input logic         clk,
  input logic         rst,
  addint_arbiter_if.slave bus
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gid;
  logic             found;
  logic             avail;
  logic             fire;
  logic [WIDTH-1:0] xs;
  logic [WIDTH-1:0] ys;
  logic [WIDTH-1:0] ym;
  logic             ss;
  logic [WIDTH:0]   sum;
  logic             ovf;
  logic [IDW-1:0]   rid;
  logic [WIDTH-1:0] rres;
  logic             rcout;
  logic             rovfl;

  // first valid requester at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    gid   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found &&
          bus.req_valid[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        gid   = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign avail = (state_q == EMPTY) || bus.out_ready;
  assign fire  = found && avail && !rst;

  assign bus.req_ready =
    fire ? (NREQ'(1) << gid) : '0;

  assign xs = bus.req_x[int'(gid)*WIDTH +: WIDTH];
  assign ys = bus.req_y[int'(gid)*WIDTH +: WIDTH];
  assign ss = bus.req_sub[gid];
  assign ym = ys ^ {WIDTH{ss}};

  assign sum = {1'b0, xs} + {1'b0, ym}
             + {{WIDTH{1'b0}}, ss};

  // same-sign operands giving a different-sign sum
  assign ovf = (xs[WIDTH-1] == ym[WIDTH-1])
            && (sum[WIDTH-1] != xs[WIDTH-1]);

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (fire) state_d = FULL;
      FULL: begin
        if (fire)               state_d = FULL;
        else if (bus.out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr   <= '0;
      rid   <= '0;
      rres  <= '0;
      rcout <= 1'b0;
      rovfl <= 1'b0;
    end else if (fire) begin
      ptr   <= (gid == IDW'(NREQ-1)) ? '0 : gid + 1'b1;
      rid   <= gid;
      rres  <= sum[WIDTH-1:0];
      rcout <= sum[WIDTH] ^ ss;
      rovfl <= ovf;
    end
  end

  assign bus.out_valid  = (state_q == FULL);
  assign bus.out_id     = rid;
  assign bus.out_result = rres;
  assign bus.out_cout   = rcout;
  assign bus.out_ovfl   = rovfl;
endmodule

// File: tb/tb_addint_arbiter.sv
// Bench for addint_arbiter: directed cases, a randomized run
// against a behavioural model, and a NREQ=3/WIDTH=8 instance.
module tb_addint_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;

  always #5 clk = ~clk;

  addint_arbiter_if #(.WIDTH(32), .NREQ(4)) bus0 ();
  addint_arbiter_if #(.WIDTH(8),  .NREQ(3)) bus1 ();

  addint_arbiter #(.WIDTH(32), .NREQ(4)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  addint_arbiter #(.WIDTH(8), .NREQ(3)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (NREQ=4, WIDTH=32)
  logic        m_valid;
  logic [1:0]  m_id;
  logic [31:0] m_res;
  logic        m_cout;
  logic        m_ovfl;
  int          m_ptr;
  int          m_acc;

  function automatic int pick(input int p, input logic [3:0] v);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  task automatic arith(input logic [31:0] x, input logic [31:0] y,
                       input logic s, output logic [31:0] r,
                       output logic c, output logic o);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint ux = longint'(x);
    longint uy = longint'(y);
    longint t;
    if (s) begin
      t = sx - sy;
      c = (ux < uy);
      r = x - y;
    end else begin
      t = sx + sy;
      c = (ux + uy) > 64'h0000_0000_FFFF_FFFF;
      r = x + y;
    end
    o = (t > 64'sd2147483647) || (t < -64'sd2147483648);
  endtask

  always @(posedge clk) begin
    int g;
    m_acc = -1;
    if (rst) begin
      m_valid = 1'b0; m_id = '0; m_res = '0;
      m_cout = 1'b0; m_ovfl = 1'b0; m_ptr = 0;
    end else begin
      g = pick(m_ptr, bus0.req_valid);
      if (g >= 0 && (!m_valid || bus0.out_ready)) begin
        arith(bus0.req_x[g*32 +: 32], bus0.req_y[g*32 +: 32],
              bus0.req_sub[g], m_res, m_cout, m_ovfl);
        m_acc   = g;
        m_valid = 1'b1;
        m_id    = 2'(g);
        m_ptr   = (g + 1) % 4;
      end else if (m_valid && bus0.out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [3:0] er;
    if (chk_en) begin
      g  = pick(m_ptr, bus0.req_valid);
      er = (!rst && g >= 0 && (!m_valid || bus0.out_ready))
         ? 4'(1 << g) : 4'b0;
      check("m_req_ready", 64'(bus0.req_ready), 64'(er));
      check("m_out_valid", 64'(bus0.out_valid), 64'(m_valid));
      check("m_out_id",    64'(bus0.out_id),    64'(m_id));
      check("m_out_result", 64'(bus0.out_result), 64'(m_res));
      check("m_out_cout",  64'(bus0.out_cout),  64'(m_cout));
      check("m_out_ovfl",  64'(bus0.out_ovfl),  64'(m_ovfl));
    end
  end

  // ---------------- stimulus helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(input int i, input logic s,
                        input logic [31:0] x, input logic [31:0] y);
    bus0.req_sub[i]         = s;
    bus0.req_x[i*32 +: 32]  = x;
    bus0.req_y[i*32 +: 32]  = y;
  endtask

  task automatic setreq1(input int i, input logic s,
                         input logic [7:0] x, input logic [7:0] y);
    bus1.req_sub[i]       = s;
    bus1.req_x[i*8 +: 8]  = x;
    bus1.req_y[i*8 +: 8]  = y;
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic out0(input string nm, input logic v,
                      input logic [1:0] id, input logic [31:0] r,
                      input logic c, input logic o);
    check({nm, "_valid"}, 64'(bus0.out_valid), 64'(v));
    check({nm, "_id"},    64'(bus0.out_id),    64'(id));
    check({nm, "_res"},   64'(bus0.out_result), 64'(r));
    check({nm, "_cout"},  64'(bus0.out_cout),  64'(c));
    check({nm, "_ovfl"},  64'(bus0.out_ovfl),  64'(o));
  endtask

  initial begin
    int dens, ordy;
    bus0.req_valid = '0; bus0.req_sub = '0;
    bus0.req_x = '0; bus0.req_y = '0; bus0.out_ready = 1'b1;
    bus1.req_valid = '0; bus1.req_sub = '0;
    bus1.req_x = '0; bus1.req_y = '0; bus1.out_ready = 1'b1;

    // reset, with a pending request that must not be granted
    cyc();
    chk_en = 1'b1;
    bus0.req_valid = 4'b0100;
    setreq(2, 1'b0, 32'd5, -32'sd3);
    @(negedge clk);
    out0("rst", 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    check("rst_ready", 64'(bus0.req_ready), 64'h0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("t1_ready", 64'(bus0.req_ready), 64'h4);
    cyc();
    bus0.req_valid = 4'b1001;
    setreq(0, 1'b1, 32'h8000_0000, 32'd1);
    setreq(3, 1'b0, 32'd1, 32'd2);
    @(negedge clk);
    out0("t1", 1'b1, 2'd2, 32'd2, 1'b1, 1'b0);
    check("t1_ptr3", 64'(bus0.req_ready), 64'h8);
    cyc();
    bus0.req_valid = 4'b0001;
    @(negedge clk);
    out0("t2a", 1'b1, 2'd3, 32'd3, 1'b0, 1'b0);
    check("t2_ready", 64'(bus0.req_ready), 64'h1);
    cyc();
    setreq(0, 1'b1, 32'd3, 32'd5);
    @(negedge clk);
    out0("t2ov", 1'b1, 2'd0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    cyc();
    bus0.req_valid = 4'b0000;
    @(negedge clk);
    out0("t2bw", 1'b1, 2'd0, 32'hFFFF_FFFE, 1'b1, 1'b0);
    cyc();
    @(negedge clk);
    out0("drain", 1'b0, 2'd0, 32'hFFFF_FFFE, 1'b1, 1'b0);

    // all four continuously valid
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) setreq(i, 1'b0, 32'(i*10), 32'(i));
    bus0.req_valid = 4'b1111;
    cyc();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      out0("rr", 1'b1, 2'(k % 4), 32'(11 * (k % 4)), 1'b0, 1'b0);
      cyc();
    end

    // backpressure
    bus0.req_valid = 4'b0000;
    cyc();
    bus0.req_valid = 4'b0010;
    setreq(1, 1'b0, 32'd100, 32'd1);
    cyc();
    bus0.out_ready = 1'b0;
    bus0.req_valid = 4'b1010;
    setreq(1, 1'b0, 32'd200, 32'd1);
    setreq(3, 1'b0, 32'd300, 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", 64'(bus0.req_ready), 64'h0);
      out0("bp", 1'b1, 2'd1, 32'd101, 1'b0, 1'b0);
      cyc();
    end
    bus0.out_ready = 1'b1;
    @(negedge clk);
    check("bp_rel", 64'(bus0.req_ready), 64'h8);
    cyc();
    bus0.req_valid = 4'b0010;
    @(negedge clk);
    out0("bp3", 1'b1, 2'd3, 32'd301, 1'b0, 1'b0);
    check("bp_next", 64'(bus0.req_ready), 64'h2);
    cyc();
    bus0.req_valid = 4'b0000;
    @(negedge clk);
    out0("bp1", 1'b1, 2'd1, 32'd201, 1'b0, 1'b0);
    cyc();

    // reset while full and stalled
    bus0.req_valid = 4'b1000;
    setreq(3, 1'b0, 32'd7, 32'd0);
    bus0.out_ready = 1'b0;
    cyc();
    bus0.req_valid = 4'b1001;
    setreq(0, 1'b0, 32'd1, 32'd1);
    setreq(3, 1'b0, 32'd9, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("r5_ready", 64'(bus0.req_ready), 64'h0);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    out0("r5", 1'b0, 2'd0, 32'd0, 1'b0, 1'b0);
    check("r5_win0", 64'(bus0.req_ready), 64'h1);
    bus0.out_ready = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      dens = (n / 500) % 3 == 0 ? 30 : ((n / 500) % 3 == 1 ? 70 : 100);
      ordy = (n / 750) % 2 == 0 ? 85 : 40;
      for (int i = 0; i < 4; i++) begin
        if (!bus0.req_valid[i] || m_acc == i) begin
          bus0.req_valid[i] = ($urandom_range(0, 99) < dens);
          setreq(i, 1'($urandom_range(0, 1)), rval(), rval());
        end
      end
      bus0.out_ready = ($urandom_range(0, 99) < ordy);
      rst = ($urandom_range(0, 299) == 0);
    end

    // NREQ=3, WIDTH=8 instance
    bus0.req_valid = '0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    bus1.req_valid = 3'b010;
    setreq1(1, 1'b0, 8'd0, 8'd0);
    cyc();
    bus1.req_valid = 3'b110;
    setreq1(1, 1'b0, 8'd127, 8'd1);
    setreq1(2, 1'b1, 8'd10, 8'd3);
    @(negedge clk);
    check("n3_ready2", 64'(bus1.req_ready), 64'h4);
    cyc();
    bus1.req_valid = 3'b010;
    @(negedge clk);
    check("n3_id2",  64'(bus1.out_id),     64'd2);
    check("n3_res2", 64'(bus1.out_result), 64'd7);
    check("n3_c2",   64'(bus1.out_cout),   64'd0);
    check("n3_ready1", 64'(bus1.req_ready), 64'h2);
    cyc();
    bus1.req_valid = 3'b000;
    @(negedge clk);
    check("n3_val",  64'(bus1.out_valid),  64'd1);
    check("n3_id1",  64'(bus1.out_id),     64'd1);
    check("n3_res1", 64'(bus1.out_result), 64'h80);
    check("n3_ov1",  64'(bus1.out_ovfl),   64'd1);
    check("n3_c1",   64'(bus1.out_cout),   64'd0);
    cyc();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
